// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Pure declarations: no latency, no flow control.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_W      = 32;

  // Low address bits that must be zero for a legal instruction address.
  localparam logic [1:0] IALIGN_MASK = 2'b11;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [INSTR_W-1:0]      instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-queue FIFO of {pc, instr}; head is visible the cycle after push (registered storage).
// Push while full or pop while empty is dropped; flush and reset empty it in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter type entry_t = fq_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   push_entry,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  // DEPTH is a power of two, so pointer overflow is the wrap-around.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one aligned imem read per cycle, 2-cycle fill into the fetch queue.
// Issue is credit-gated on count+inflight < FQ_DEPTH; redirect flushes queue and in-flight word.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FQ_DEPTH     = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  output logic                        o_imem_req,
  output logic [XLEN-1:0]             o_imem_addr,
  input  logic [INSTR_W-1:0]          i_imem_rdata,
  input  logic                        i_redirect,
  input  logic [XLEN-1:0]             i_redirect_addr,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [XLEN-1:0]             o_address,
  output logic [INSTR_W-1:0]          o_instruccion,
  output logic [$clog2(FQ_DEPTH):0]   o_fq_count
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  inflight_pc;
  logic             inflight;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] fq_count;
  logic [CNT_W:0]   credit_used;
  logic             issue;
  logic             push;
  logic             pop;
  entry_t           push_entry;
  entry_t           head;

  assign redirect_pc = {i_redirect_addr[XLEN-1:2], i_redirect_addr[1:0] & ~IALIGN_MASK};

  // A pop in the same cycle does not return a credit; this keeps the
  // occupancy bound independent of decode's ready timing.
  assign credit_used = {1'b0, fq_count} + (CNT_W+1)'(inflight);
  assign issue       = !i_reset && !i_redirect && (credit_used < (CNT_W+1)'(FQ_DEPTH));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pc          <= RESET_VECTOR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (i_redirect) begin
      pc          <= redirect_pc;
      inflight    <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + XLEN'(4);
        inflight_pc <= pc;
      end
    end
  end

  assign push       = inflight && !i_redirect && !i_reset;
  assign pop        = o_valid && i_ready && !i_redirect && !i_reset;
  assign push_entry = '{pc: inflight_pc, instr: i_imem_rdata};

  fetch_queue #(
    .entry_t (entry_t),
    .DEPTH   (FQ_DEPTH)
  ) u_fetch_queue (
    .clock      (i_clock),
    .reset      (i_reset),
    .flush      (i_redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fq_count)
  );

  assign o_imem_req    = issue;
  assign o_imem_addr   = pc;
  assign o_valid       = (fq_count != '0);
  assign o_address     = o_valid ? head.pc    : '0;
  assign o_instruccion = o_valid ? head.instr : '0;
  assign o_fq_count    = fq_count;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage, next generation of the single-cycle fetch path. It owns the program counter, issues one aligned read per cycle to a synchronous instruction memory (1-cycle read latency), and tags each returned word with its PC. Fetched pairs are buffered in a small fetch queue and presented to decode through a valid/ready handshake. A branch redirect flushes all buffered and in-flight fetches and restarts fetch at the target.

## Interface
- XLEN, 32, address/PC width
- RESET_VECTOR, 0, PC value loaded on reset (must be 4-byte aligned)
- FQ_DEPTH, 4, fetch-queue entries; power of two, minimum 2; 4 or more required for full throughput

- i_clock  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- o_imem_req  out  1  read request to instruction memory this cycle
- o_imem_addr  out  XLEN  read address, always 4-byte aligned
- i_imem_rdata  in  32  read data; valid the cycle after the matching request
- i_redirect  in  1  branch/jump taken; flush and restart
- i_redirect_addr  in  XLEN  redirect target; bits [1:0] ignored
- o_valid  out  1  queue head holds a valid instruction
- i_ready  in  1  decode accepts head this cycle
- o_address  out  XLEN  PC of head instruction
- o_instruccion  out  32  head instruction word
- o_fq_count  out  $clog2(FQ_DEPTH)+1  current queue occupancy

## Operation
- Issue rule: o_imem_req=1 when not in reset, no redirect this cycle, and count + inflight < FQ_DEPTH. Same-cycle pop is not credited.
- On issue: o_imem_addr=PC; PC <= PC+4, wrapping modulo 2^XLEN. inflight <= 1.
- Return: when inflight=1, {issued PC, i_imem_rdata} is pushed next cycle. Because the credit rule guarantees space, overflow is impossible.
- Pop: o_valid && i_ready removes the head. Push and pop in the same cycle leave count unchanged.
- Redirect has the highest priority, above push, pop and issue:
  - queue is emptied and inflight is cleared, so the returning word is discarded;
  - PC <= {i_redirect_addr[XLEN-1:2], 2'b00};
  - no request is issued in the redirect cycle;
  - a pop in the same cycle is ignored, and the head is not consumed.
- When o_valid=0, o_address and o_instruccion are driven to 0.

## Timing
- Reset (i_reset=1 at an edge):
  - PC=RESET_VECTOR, count=0, inflight=0;
  - o_valid=0, o_imem_req=0, o_imem_addr=RESET_VECTOR, o_address=0, o_instruccion=0, o_fq_count=0;
  - i_redirect and i_ready are ignored while i_reset=1;
  - reset mid-operation discards all queued and in-flight fetches.
- First cycle after reset (C0): req at RESET_VECTOR. C1: rdata returns. C2: o_valid=1, o_address=RESET_VECTOR.
- Redirect sampled in cycle R: R+1 req at target, R+2 rdata, R+3 o_valid with target. Penalty is 3 cycles.
- Steady state with i_ready=1 and FQ_DEPTH>=4: one instruction per cycle.
- Back-pressure: with i_ready=0, requests stop once count+inflight reaches FQ_DEPTH. The queue then holds exactly FQ_DEPTH entries, and no entry is lost or duplicated.

## Structure
- Package fetch_pkg holds:
  - XLEN default and INSTR_W=32;
  - typedef fq_entry_t = {pc[XLEN-1:0], instr[31:0]};
  - constant IALIGN_MASK.
- Sub-module fetch_queue: synchronous FIFO of fq_entry_t with depth FQ_DEPTH, plus push/pop/flush ports, count output and wrap-around pointers.
- fetch_unit contains the PC register, inflight flag, issue/credit logic and redirect control.

## Test plan
- Reset release, RESET_VECTOR=0x100, i_ready=1: requests at 0x100, 0x104, 0x108…; o_valid first in C2 with o_address=0x100, then one new address per cycle.
- i_ready=0 for 10 cycles, FQ_DEPTH=4: o_fq_count saturates at 4 and o_imem_req stays 0. On release the drain order is 0x100, 0x104, 0x108, 0x10C, 0x110, with no gaps or duplicates.
- i_redirect with i_redirect_addr=0x2003 while the queue is full and a fetch is in flight: queue empties next cycle, the in-flight word is dropped, and req at 0x2000 follows. o_valid returns in R+3 with o_address=0x2000.
- Redirect and i_ready=1 in the same cycle: the head is not counted as accepted, and the next valid output is the target instruction.
- PC near wrap, XLEN=32, redirect to 0xFFFFFFFC: following addresses are 0xFFFFFFFC, 0x00000000, 0x00000004.
- i_reset asserted mid-stream with 3 entries queued: the next cycle shows o_valid=0, o_fq_count=0 and PC=RESET_VECTOR, and a stale word returning from memory is not pushed.
